// File: rtl/multibit_fifo_ring.sv
// -----------------------------------------------------------------------------
// multibit_fifo_ring
//
// Single-clock FIFO with valid/ready handshakes on both sides. Depth is any
// power of two; pointers carry one extra wrap bit so full and empty can be
// told apart without a separate flag. Adds an occupancy count, programmable
// almost-full/almost-empty flags and a synchronous flush.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1 on that side. The producer may change avalid/adata freely while
// aready is 0. bdata is stable while bvalid is 1 and no pop occurs.
//
// Ports:
//   clk           clock, all logic on posedge
//   reset         synchronous active-high reset (priority over flush)
//   flush         synchronous discard of all stored entries
//   avalid/adata  write side request and payload
//   aready        write side ready (not full, not in reset)
//   bvalid/bdata  read side valid (not empty, not in reset) and head entry
//   bready        read side ready
//   count         occupancy, 0..DEPTH
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
// -----------------------------------------------------------------------------
module multibit_fifo_ring #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           avalid,
    input  logic [DATA_WIDTH-1:0]          adata,
    output logic                           aready,
    output logic                           bvalid,
    output logic [DATA_WIDTH-1:0]          bdata,
    input  logic                           bready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           almost_full,
    output logic                           almost_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] AFULL_T  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_T = CNT_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]       r_wptr;
    logic [ADDR_W:0]       r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]) &&
                     (r_wptr[ADDR_W] != r_rptr[ADDR_W]);

    assign aready = ~w_full & ~reset;
    assign bvalid = ~w_empty & ~reset;

    assign w_push = avalid & aready;
    assign w_pop  = bvalid & bready;

    // Head entry read straight from the array; no write-through bypass.
    assign bdata = r_mem[r_rptr[ADDR_W-1:0]];

    assign count        = r_count;
    assign almost_full  = (r_count >= AFULL_T);
    assign almost_empty = (r_count <= AEMPTY_T);

    // Storage has no reset. A push coinciding with flush is dropped, so the
    // array is only written when the pointer will actually advance.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= adata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_multibit_fifo_ring.sv
// -----------------------------------------------------------------------------
// tb_multibit_fifo_ring
//
// Two instances: u_dut4 (8-bit, depth 4, default thresholds) exercised by a
// vector table plus a streaming sequence, and u_dut8 (16-bit, depth 8,
// thresholds 6/2) exercised by random valid/ready against a reference queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_multibit_fifo_ring;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- depth-4 instance ----------------
    logic       reset4, flush4, avalid4, bready4;
    logic [7:0] adata4, bdata4;
    logic       aready4, bvalid4, afull4, aempty4;
    logic [2:0] count4;

    multibit_fifo_ring #(
        .DATA_WIDTH(8), .DEPTH(4)
    ) u_dut4 (
        .clk(clk), .reset(reset4), .flush(flush4),
        .avalid(avalid4), .adata(adata4), .aready(aready4),
        .bvalid(bvalid4), .bdata(bdata4), .bready(bready4),
        .count(count4), .almost_full(afull4), .almost_empty(aempty4)
    );

    // ---------------- depth-8 instance ----------------
    logic        reset8, flush8, avalid8, bready8;
    logic [15:0] adata8, bdata8;
    logic        aready8, bvalid8, afull8, aempty8;
    logic [3:0]  count8;

    multibit_fifo_ring #(
        .DATA_WIDTH(16), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) u_dut8 (
        .clk(clk), .reset(reset8), .flush(flush8),
        .avalid(avalid8), .adata(adata8), .aready(aready8),
        .bvalid(bvalid8), .bdata(bdata8), .bready(bready8),
        .count(count8), .almost_full(afull8), .almost_empty(aempty8)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, fl, av;
        logic [7:0] ad;
        logic       br;
        logic       ar, bv;
        logic [7:0] bd;
        logic [2:0] cnt;
        logic       af, ae;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic fl, input logic av, input logic [7:0] ad,
                       input logic br, input logic ar, input logic bv, input logic [7:0] bd,
                       input logic [2:0] cnt, input logic af, input logic ae);
        vec_t v;
        v.rst = rst; v.fl = fl; v.av = av; v.ad = ad; v.br = br;
        v.ar = ar; v.bv = bv; v.bd = bd; v.cnt = cnt; v.af = af; v.ae = ae;
        vecs.push_back(v);
    endtask

    // Scoreboards
    logic [7:0]  exp_q[$];
    logic [15:0] exp8_q[$];

    initial begin
        //    rst fl av  ad     br | ar bv  bd     cnt   af ae   (outputs before the edge)
        add(H, L, H, 8'h55, L,  L, L, 8'h00, 3'd0, L, H);   // reset held, avalid=1
        add(H, L, H, 8'h55, L,  L, L, 8'h00, 3'd0, L, H);
        add(H, L, H, 8'h55, L,  L, L, 8'h00, 3'd0, L, H);
        add(L, L, H, 8'h11, L,  H, L, 8'h00, 3'd0, L, H);   // push 11
        add(L, L, H, 8'h22, L,  H, H, 8'h11, 3'd1, L, H);   // push 22
        add(L, L, H, 8'h33, L,  H, H, 8'h11, 3'd2, L, L);   // push 33
        add(L, L, H, 8'h44, L,  H, H, 8'h11, 3'd3, H, L);   // push 44
        add(L, L, H, 8'h55, L,  L, H, 8'h11, 3'd4, H, L);   // full: 55 held
        add(L, L, H, 8'h55, H,  L, H, 8'h11, 3'd4, H, L);   // full + both: pop only
        add(L, L, H, 8'h55, H,  H, H, 8'h22, 3'd3, H, L);   // both occur
        add(L, L, L, 8'h00, H,  H, H, 8'h33, 3'd3, H, L);
        add(L, L, L, 8'h00, H,  H, H, 8'h44, 3'd2, L, L);
        add(L, L, L, 8'h00, H,  H, H, 8'h55, 3'd1, L, H);
        add(L, L, L, 8'h00, L,  H, L, 8'h00, 3'd0, L, H);   // empty
        add(L, L, H, 8'hA1, L,  H, L, 8'h00, 3'd0, L, H);
        add(L, L, H, 8'hA2, L,  H, H, 8'hA1, 3'd1, L, H);
        add(L, L, H, 8'hA3, L,  H, H, 8'hA1, 3'd2, L, L);
        add(L, H, H, 8'hAA, H,  H, H, 8'hA1, 3'd3, H, L);   // flush beats push+pop
        add(L, L, H, 8'hBB, L,  H, L, 8'h00, 3'd0, L, H);   // AA not stored
        add(L, L, L, 8'h00, L,  H, H, 8'hBB, 3'd1, L, H);
        add(L, H, L, 8'h00, L,  H, H, 8'hBB, 3'd1, L, H);   // flush alone
        add(L, L, H, 8'hCC, H,  H, L, 8'h00, 3'd0, L, H);   // empty + both: push only
        add(L, L, L, 8'h00, H,  H, H, 8'hCC, 3'd1, L, H);
        add(H, L, H, 8'hDD, L,  L, L, 8'h00, 3'd0, L, H);   // reset mid-stream
        add(L, L, H, 8'hEE, L,  H, L, 8'h00, 3'd0, L, H);
        add(L, L, L, 8'h00, L,  H, H, 8'hEE, 3'd1, L, H);
        add(L, L, L, 8'h00, H,  H, H, 8'hEE, 3'd1, L, H);   // drain

        reset4 = 1'b1; flush4 = 1'b0; avalid4 = 1'b1; adata4 = 8'h55; bready4 = 1'b0;
        reset8 = 1'b1; flush8 = 1'b0; avalid8 = 1'b1; adata8 = 16'h0; bready8 = 1'b0;
        @(posedge clk);

        // ---------- table phase ----------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset4  = vecs[i].rst;
            flush4  = vecs[i].fl;
            avalid4 = vecs[i].av;
            adata4  = vecs[i].ad;
            bready4 = vecs[i].br;
            #1;
            check($sformatf("vec%0d aready", i), 32'(aready4), 32'(vecs[i].ar));
            check($sformatf("vec%0d bvalid", i), 32'(bvalid4), 32'(vecs[i].bv));
            check($sformatf("vec%0d count", i),  32'(count4),  32'(vecs[i].cnt));
            check($sformatf("vec%0d afull", i),  32'(afull4),  32'(vecs[i].af));
            check($sformatf("vec%0d aempty", i), 32'(aempty4), 32'(vecs[i].ae));
            if (vecs[i].bv) begin
                check($sformatf("vec%0d bdata", i), 32'(bdata4), 32'(vecs[i].bd));
            end
        end

        // ---------- streaming wrap on depth 4 ----------
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            avalid4 = 1'b1;
            adata4  = 8'(i);
            bready4 = 1'b1;
            #1;
            check($sformatf("stream%0d aready", i), 32'(aready4), 32'd1);
            check($sformatf("stream%0d count", i), 32'(count4), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("stream%0d bvalid", i), 32'(bvalid4), (i == 0) ? 32'd0 : 32'd1);
            if (bvalid4 && exp_q.size() > 0) begin
                check($sformatf("stream%0d bdata", i), 32'(bdata4), 32'(exp_q.pop_front()));
            end
            if (aready4) exp_q.push_back(adata4);
        end
        @(negedge clk);
        avalid4 = 1'b0;
        bready4 = 1'b1;
        #1;
        check("stream tail bvalid", 32'(bvalid4), 32'd1);
        if (exp_q.size() > 0) check("stream tail bdata", 32'(bdata4), 32'(exp_q.pop_front()));
        @(negedge clk);
        bready4 = 1'b0;
        #1;
        check("stream end bvalid", 32'(bvalid4), 32'd0);
        check("stream scoreboard empty", 32'(exp_q.size()), 32'd0);

        // ---------- randomised depth 8 ----------
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset8 = 1'b1; avalid8 = 1'b1;
            #1;
            check("r8 reset aready", 32'(aready8), 32'd0);
            check("r8 reset bvalid", 32'(bvalid8), 32'd0);
            check("r8 reset count", 32'(count8), 32'd0);
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int wb;
            int rb;
            logic do_pop;
            logic do_push;
            case ((cyc / 1000) % 3)
                0:       begin wb = 75; rb = 30; end
                1:       begin wb = 30; rb = 75; end
                default: begin wb = 55; rb = 55; end
            endcase
            @(negedge clk);
            reset8  = 1'b0;
            flush8  = ($urandom_range(0, 199) == 0);
            avalid8 = ($urandom_range(0, 99) < wb);
            bready8 = ($urandom_range(0, 99) < rb);
            adata8  = 16'($urandom_range(0, 65535));
            #1;
            check("r8 count",  32'(count8),  32'(exp8_q.size()));
            check("r8 aready", 32'(aready8), 32'(exp8_q.size() < 8));
            check("r8 bvalid", 32'(bvalid8), 32'(exp8_q.size() > 0));
            check("r8 afull",  32'(afull8),  32'(exp8_q.size() >= 6));
            check("r8 aempty", 32'(aempty8), 32'(exp8_q.size() <= 2));
            if (exp8_q.size() > 0) check("r8 bdata", 32'(bdata8), 32'(exp8_q[0]));
            if (flush8) begin
                exp8_q.delete();
            end else begin
                do_pop  = bready8 && (exp8_q.size() > 0);
                do_push = avalid8 && (exp8_q.size() < 8);
                if (do_pop) void'(exp8_q.pop_front());
                if (do_push) exp8_q.push_back(adata8);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multibit_fifo_ring.md
# multibit_fifo_ring

Parametrised single-clock FIFO with a valid/ready handshake on both sides, generalising the 1-deep toggle-pointer buffer to any power-of-two depth. It adds an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It sits between same-clock producer/consumer stages in the datapath, and on either side of the CDC synchronizers where a domain needs elastic buffering.

## Interface
- DATA_WIDTH, 32, payload width in bits (>=1)
- DEPTH, 4, number of entries; power of two, >=2
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= this value (1..DEPTH)
- AEMPTY_THRESH, 1, almost_empty asserts when count <= this value (0..DEPTH-1)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all stored entries
- avalid  in  1  write-side valid
- adata  in  DATA_WIDTH  write-side payload
- aready  out  1  write-side ready (FIFO not full)
- bvalid  out  1  read-side valid (FIFO not empty)
- bdata  out  DATA_WIDTH  read-side payload (head entry)
- bready  in  1  read-side ready
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH

## Operation
- Storage: DEPTH x DATA_WIDTH register array, written on clk; no reset on the array.
- Pointers wptr, rptr: ADDR_W+1 bits each, where ADDR_W = $clog2(DEPTH). The low ADDR_W bits address the array; the MSB is the wrap/toggle bit.
- empty = (wptr == rptr). full = (low bits equal) && (MSBs differ).
- aready = ~full & ~reset; bvalid = ~empty & ~reset.
- push = avalid & aready: write adata to mem[wptr low bits], then wptr += 1, wrapping modulo 2*DEPTH.
- pop = bvalid & bready: rptr += 1, wrapping modulo 2*DEPTH.
- bdata = mem[rptr low bits], combinational read. It holds stable while bvalid=1 and no pop occurs.
- count register: +1 on push only, -1 on pop only, unchanged on both or neither. It always equals wptr - rptr (mod 2*DEPTH).
- almost_full and almost_empty decode combinationally from the count register.
- Flush has priority over push and pop in the same cycle. It sets wptr=rptr=0 and count=0. Any push that cycle is discarded, even though aready may read 1. Array contents are left stale.
- Reset has priority over flush, with the same pointer/count effect.
- No bypass path: a word written into an empty FIFO is never presented on bdata in the same cycle.
- avalid/adata need not be held by the producer when aready=0. No requirement on the producer beyond sampling at the clock edge.

## Timing
- Reset values: wptr=rptr=0, count=0, aready=0 and bvalid=0 while reset is high. The cycle after reset deasserts: aready=1, bvalid=0, almost_empty=1. almost_full=0 unless AFULL_THRESH=0, which is illegal.
- Write-to-read latency: a push at edge N gives bvalid=1 and that word on bdata after edge N.
- Full: after the DEPTH-th push with no pops, aready=0 from the next cycle. If a pop and a push request occur together while full, only the pop is taken, because aready is already 0. aready returns 1 the cycle after the pop.
- Empty: a simultaneous push and pop request while empty takes the push only. bvalid rises next cycle.
- Simultaneous push and pop when neither full nor empty: both occur and count is unchanged.
- Throughput: one push and one pop per cycle sustained.
- Pointer wrap: after 2*DEPTH pushes, wptr returns to 0. Full/empty decode stays correct across every wrap.
- Reset or flush mid-stream: queued data is lost. The first push afterwards lands at index 0.

## Test plan
- Reset/idle: hold reset 3 cycles with avalid=1 -> aready=0, bvalid=0 and count=0 throughout. After release: aready=1, almost_empty=1.
- Fill/drain (DATA_WIDTH=8, DEPTH=4, bready=0): push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; aready=0 after the 4th push. A 5th write of 0x55 is held and not accepted. Set bready=1 -> bdata 0x11,0x22,0x33,0x44 in order, then 0x55 is accepted once aready=1.
- Streaming wrap: avalid=bready=1 for 20 cycles with an incrementing payload 0x00..0x13 -> output sequence is identical with no gaps after the first-word latency of 1. Count holds at 1 and pointers wrap at least twice.
- Full with simultaneous events: while full, assert avalid=bready=1 for one cycle -> only the pop occurs and count goes 4 -> 3. Next cycle both occur and count stays 3.
- Flush: with count=3, assert flush together with avalid=1 (data 0xAA) and bready=1 -> next cycle count=0, bvalid=0, 0xAA not stored. A following push of 0xBB appears on bdata one cycle later.
- Randomised valid/ready against a scoreboard queue (DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2) for 10k cycles -> no loss, duplication or reordering. count, almost_full and almost_empty match the model every cycle.
